trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data/PC width.
REQ-002 SHALL have parameter MTVEC_ALIGN, default 2, meaning low mtvec bits forced to zero on redirect.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall_i  input  1  pipeline stall; freezes the controller.
REQ-006 SHALL have port ecall_i  input  1  ecall retiring this cycle.
REQ-007 SHALL have port mret_i  input  1  mret retiring this cycle.
REQ-008 SHALL have port pc_i  input  XLEN  PC of the retiring ecall.
REQ-009 SHALL have port busy_o  output  1  sequence in progress; front-end holds issue.
REQ-010 SHALL have port csr_re_o  output  1  CSR read enable.
REQ-011 SHALL have port csr_raddr_o  output  12  CSR read address.
REQ-012 SHALL have port csr_rdata_i  input  XLEN  CSR read data, same-cycle combinational.
REQ-013 SHALL have port csr_we_o  output  1  CSR write enable.
REQ-014 SHALL have port csr_waddr_o  output  12  CSR write address.
REQ-015 SHALL have port csr_wdata_o  output  XLEN  CSR write data.
REQ-016 SHALL have port redirect_o  output  1  one-cycle PC redirect/flush pulse.
REQ-017 SHALL have port redirect_pc_o  output  XLEN  redirect target, valid when redirect_o=1.

Function
REQ-018 SHALL implement states IDLE, WR_MEPC, WR_MCAUSE, RD_MSTATUS, WR_MSTATUS, RD_TARGET, REDIRECT.
REQ-019 In IDLE: ecall_i=1 SHALL capture pc_i, set mode=ECALL, and go to WR_MEPC. Else mret_i=1 SHALL set mode=MRET and go to RD_MSTATUS. Ecall wins if both are asserted.
REQ-020 ecall_i/mret_i SHALL be ignored in every non-IDLE state.
REQ-021 WR_MEPC SHALL assert csr_we_o with waddr 0x341 and wdata = captured PC (no +4), then go to WR_MCAUSE.
REQ-022 WR_MCAUSE SHALL assert csr_we_o with waddr 0x342 and wdata = 11 (zero-extended), then go to RD_MSTATUS.
REQ-023 RD_MSTATUS SHALL assert csr_re_o with raddr 0x300, register csr_rdata_i into an internal mstatus copy, then go to WR_MSTATUS.
REQ-024 WR_MSTATUS, mode ECALL, SHALL write 0x300 with copy modified as follows: bit7(MPIE)=old bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11; other bits unchanged.
REQ-025 WR_MSTATUS, mode MRET, SHALL write 0x300 with copy modified as follows: bit3=old bit7, bit7=1, bits12:11=2'b11; other bits unchanged.
REQ-026 After WR_MSTATUS, SHALL go to RD_TARGET.
REQ-027 RD_TARGET SHALL read 0x305 (ECALL) or 0x341 (MRET) and register the target, then go to REDIRECT.
REQ-028 ECALL target SHALL have its low MTVEC_ALIGN bits cleared; MRET target SHALL be taken unmodified.
REQ-029 REDIRECT SHALL drive redirect_o=1 and redirect_pc_o=target for exactly one cycle, then go to IDLE.
REQ-030 busy_o SHALL be 1 in every state except IDLE, registered so it rises the cycle after acceptance.
REQ-031 Latency: ecall accept edge to redirect_o SHALL be 6 cycles; mret SHALL be 4 cycles (no stalls).
REQ-032 While stall_i=1: state, captured PC, copies and target SHALL hold. csr_we_o, csr_re_o and redirect_o SHALL be forced 0. The sequence SHALL resume unchanged after stall_i falls.
REQ-033 csr_we_o and csr_re_o SHALL never be asserted in the same cycle.
REQ-034 When an enable is 0, its address/data outputs SHALL be driven to zero.
REQ-035 redirect_pc_o SHALL be zero when redirect_o=0.

Reset
REQ-036 rst=1 SHALL asynchronously force state=IDLE and clear all registers. All outputs SHALL read 0 while rst is high.
REQ-037 Reset mid-sequence SHALL abandon it; no further CSR writes or redirects occur for that trap.
REQ-038 After rst falls, the first clock edge SHALL accept a new request.

Verification
REQ-039 ecall, pc_i=0x8000_0010, mtvec=0x8000_0103, mstatus=0x8 -> writes 0x341=0x8000_0010, 0x342=0xB, 0x300=0x1880; redirect_pc_o=0x8000_0100 on cycle 6.
REQ-040 mret, mstatus=0x1880, mepc=0x8000_0014 -> write 0x300=0x1888; redirect_pc_o=0x8000_0014 on cycle 4.
REQ-041 ecall_i and mret_i both asserted -> ecall sequence only; a second mret_i pulse during busy_o=1 is ignored.
REQ-042 stall_i high for 3 cycles while in WR_MCAUSE -> no write during the stall; 0x342 written once after release; redirect delayed by exactly 3 cycles.
REQ-043 rst pulse between clock edges while in WR_MSTATUS -> outputs 0 immediately; no 0x300 write and no redirect.
REQ-044 Back-to-back: ecall, then ecall on the cycle after redirect -> both sequences complete correctly with IDLE lasting 1 cycle.

Source files
------------

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- machine-mode ecall / mret sequencer.
//
// An ecall or mret that retires while the controller is idle starts a short
// sequence of CSR accesses:
//   ecall : write mepc, write mcause, read/modify/write mstatus,
//           read mtvec, redirect
//   mret  : read/modify/write mstatus, read mepc, redirect
// While the sequence runs, busy_o tells the front-end to hold issue.
// stall_i freezes the controller in place.
//
// Parameters
//   XLEN        : data / PC width
//   MTVEC_ALIGN : number of low mtvec bits cleared on an ecall redirect
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   stall_i         : pipeline stall; holds all state and suppresses strobes
//   ecall_i, mret_i : retiring ecall / mret (sampled only when idle)
//   pc_i            : PC of the retiring ecall
//   busy_o          : sequence in progress (registered)
//   csr_re_o, csr_raddr_o, csr_rdata_i : CSR read port (combinational data)
//   csr_we_o, csr_waddr_o, csr_wdata_o : CSR write port
//   redirect_o, redirect_pc_o          : one-cycle PC redirect and its target
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int XLEN        = 64,
    parameter int MTVEC_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            busy_o,
    output logic            csr_re_o,
    output logic [11:0]     csr_raddr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] MCAUSE_ECALL_M = {{(XLEN-4){1'b0}}, 4'd11};
    // Clears the low MTVEC_ALIGN bits of the trap vector.
    localparam logic [XLEN-1:0] TVEC_MASK =
        ~((XLEN'(1'b1) << MTVEC_ALIGN) - XLEN'(1'b1));

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_MEPC    = 3'd1,
        S_WR_MCAUSE  = 3'd2,
        S_RD_MSTATUS = 3'd3,
        S_WR_MSTATUS = 3'd4,
        S_RD_TARGET  = 3'd5,
        S_REDIRECT   = 3'd6
    } state_t;

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
    function automatic logic [XLEN-1:0] mstatus_ret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    state_t          state_r, state_nxt_s;
    logic            mode_mret_r, mode_mret_nxt_s;   // 0 = ecall, 1 = mret
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] mstatus_r, mstatus_nxt_s;
    logic [XLEN-1:0] target_r, target_nxt_s;
    logic            busy_r;

    // State and datapath registers; all hold values come from the comb block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            mode_mret_r <= 1'b0;
            pc_r        <= '0;
            mstatus_r   <= '0;
            target_r    <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mode_mret_r <= mode_mret_nxt_s;
            pc_r        <= pc_nxt_s;
            mstatus_r   <= mstatus_nxt_s;
            target_r    <= target_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
        end
    end

    assign busy_o = busy_r;

    // Next-state and output decode. A stall keeps every register and
    // forces all strobes (and therefore their address/data) to zero.
    always_comb begin
        state_nxt_s     = state_r;
        mode_mret_nxt_s = mode_mret_r;
        pc_nxt_s        = pc_r;
        mstatus_nxt_s   = mstatus_r;
        target_nxt_s    = target_r;
        csr_re_o        = 1'b0;
        csr_raddr_o     = 12'h000;
        csr_we_o        = 1'b0;
        csr_waddr_o     = 12'h000;
        csr_wdata_o     = '0;
        redirect_o      = 1'b0;
        redirect_pc_o   = '0;

        if (stall_i) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // ecall has priority over a simultaneous mret.
                    if (ecall_i) begin
                        pc_nxt_s        = pc_i;
                        mode_mret_nxt_s = 1'b0;
                        state_nxt_s     = S_WR_MEPC;
                    end else if (mret_i) begin
                        mode_mret_nxt_s = 1'b1;
                        state_nxt_s     = S_RD_MSTATUS;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_WR_MEPC: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = pc_r;
                    state_nxt_s = S_WR_MCAUSE;
                end
                S_WR_MCAUSE: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = MCAUSE_ECALL_M;
                    state_nxt_s = S_RD_MSTATUS;
                end
                S_RD_MSTATUS: begin
                    csr_re_o      = 1'b1;
                    csr_raddr_o   = CSR_MSTATUS;
                    mstatus_nxt_s = csr_rdata_i;
                    state_nxt_s   = S_WR_MSTATUS;
                end
                S_WR_MSTATUS: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    if (mode_mret_r) begin
                        csr_wdata_o = mstatus_ret(mstatus_r);
                    end else begin
                        csr_wdata_o = mstatus_trap(mstatus_r);
                    end
                    state_nxt_s = S_RD_TARGET;
                end
                S_RD_TARGET: begin
                    csr_re_o = 1'b1;
                    if (mode_mret_r) begin
                        csr_raddr_o  = CSR_MEPC;
                        target_nxt_s = csr_rdata_i;
                    end else begin
                        csr_raddr_o  = CSR_MTVEC;
                        target_nxt_s = csr_rdata_i & TVEC_MASK;
                    end
                    state_nxt_s = S_REDIRECT;
                end
                S_REDIRECT: begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = target_r;
                    state_nxt_s   = S_IDLE;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl -- directed scoreboard bench for trap_ctrl.
// Stimulus pushes the expected CSR writes and redirects (with the cycle on
// which each must appear) into a queue; a monitor pops and compares every
// write/redirect the DUT presents on the falling edge.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall_i = 1'b0;
    logic            ecall_i = 1'b0;
    logic            mret_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic            busy_o;
    logic            csr_re_o;
    logic [11:0]     csr_raddr_o;
    logic [XLEN-1:0] csr_rdata_i;
    logic            csr_we_o;
    logic [11:0]     csr_waddr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    // Bench-owned CSR contents returned on reads.
    logic [XLEN-1:0] mstatus_m = '0;
    logic [XLEN-1:0] mtvec_m   = '0;
    logic [XLEN-1:0] mepc_m    = '0;

    int cyc_cnt = 0;
    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic            is_redir;
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;
    exp_t exp_q[$];

    trap_ctrl #(.XLEN(XLEN), .MTVEC_ALIGN(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .ecall_i(ecall_i),
        .mret_i(mret_i), .pc_i(pc_i), .busy_o(busy_o),
        .csr_re_o(csr_re_o), .csr_raddr_o(csr_raddr_o),
        .csr_rdata_i(csr_rdata_i), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Combinational CSR read data.
    always_comb begin
        csr_rdata_i = '0;
        if (csr_re_o) begin
            case (csr_raddr_o)
                12'h300: csr_rdata_i = mstatus_m;
                12'h305: csr_rdata_i = mtvec_m;
                12'h341: csr_rdata_i = mepc_m;
                default: csr_rdata_i = '0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [XLEN-1:0] d, input int c);
        exp_t e;
        e.is_redir = 1'b0; e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_redir(input logic [XLEN-1:0] d, input int c);
        exp_t e;
        e.is_redir = 1'b1; e.addr = 12'h000; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input logic is_redir, input logic [11:0] a,
                               input logic [XLEN-1:0] d);
        exp_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_event: got redir=%0b addr=%h data=%h cyc=%0d, expected none",
                     is_redir, a, d, cyc_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.is_redir !== is_redir || e.addr !== a || e.data !== d || e.cyc != cyc_cnt) begin
                tests_failed++;
                $display("FAIL event: got redir=%0b addr=%h data=%h cyc=%0d, expected redir=%0b addr=%h data=%h cyc=%0d",
                         is_redir, a, d, cyc_cnt, e.is_redir, e.addr, e.data, e.cyc);
            end
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 30) begin
            wait_edge();
            n++;
        end
        chk(name, {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        int a;
        fork
            // Monitor: compare every strobe the DUT presents.
            forever begin
                @(negedge clk);
                if (csr_we_o && csr_re_o) begin
                    chk("we_re_exclusive", 64'd1, 64'd0);
                end
                if (!csr_we_o && (csr_waddr_o != 12'h000 || csr_wdata_o != '0)) begin
                    chk("wr_bus_idle_zero", {52'd0, csr_waddr_o} | csr_wdata_o, 64'd0);
                end
                if (!csr_re_o && csr_raddr_o != 12'h000) begin
                    chk("rd_addr_idle_zero", {52'd0, csr_raddr_o}, 64'd0);
                end
                if (!redirect_o && redirect_pc_o != '0) begin
                    chk("redirect_pc_idle_zero", redirect_pc_o, 64'd0);
                end
                if (csr_we_o) check_event(1'b0, csr_waddr_o, csr_wdata_o);
                if (redirect_o) check_event(1'b1, 12'h000, redirect_pc_o);
            end
            begin
                // Reset state: every output zero while rst is high.
                repeat (2) wait_edge();
                chk("rst_busy", {63'd0, busy_o}, 64'd0);
                chk("rst_strobes", {61'd0, csr_we_o, csr_re_o, redirect_o}, 64'd0);
                chk("rst_buses", csr_wdata_o | redirect_pc_o | {52'd0, csr_waddr_o} | {52'd0, csr_raddr_o}, 64'd0);

                // ecall accepted on the first edge after reset release.
                mstatus_m = 64'h8;
                mtvec_m   = 64'h8000_0103;
                rst = 1'b0; ecall_i = 1'b1; pc_i = 64'h8000_0010;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h8000_0010, a);
                push_wr(12'h342, 64'hB, a + 1);
                push_wr(12'h300, 64'h1880, a + 3);
                push_redir(64'h8000_0100, a + 5);
                chk("busy_before_accept", {63'd0, busy_o}, 64'd0);
                wait_edge();
                ecall_i = 1'b0;
                chk("busy_after_accept", {63'd0, busy_o}, 64'd1);
                wait_idle("ecall1_done");

                // mret
                mstatus_m = 64'h1880;
                mepc_m    = 64'h8000_0014;
                mret_i = 1'b1;
                a = cyc_cnt + 1;
                push_wr(12'h300, 64'h1888, a + 1);
                push_redir(64'h8000_0014, a + 3);
                wait_edge();
                mret_i = 1'b0;
                wait_idle("mret_done");

                // ecall and mret together, then a stray mret while busy.
                mstatus_m = 64'hA000_0000_0000_0077;
                mtvec_m   = 64'h2000_00FF;
                ecall_i = 1'b1; mret_i = 1'b1; pc_i = 64'h0000_0040_0000_0AB4;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h0000_0040_0000_0AB4, a);
                push_wr(12'h342, 64'hB, a + 1);
                push_wr(12'h300, 64'hA000_0000_0000_1877, a + 3);
                push_redir(64'h2000_00FC, a + 5);
                wait_edge();
                ecall_i = 1'b0; mret_i = 1'b0;
                wait_edge();
                mret_i = 1'b1;
                chk("busy_during_stray_mret", {63'd0, busy_o}, 64'd1);
                wait_edge();
                mret_i = 1'b0;
                wait_idle("both_done");

                // Stall for three cycles in WR_MCAUSE.
                mstatus_m = 64'hA;
                mtvec_m   = 64'hFFFF_FFFF_FFFF_FFFF;
                ecall_i = 1'b1; pc_i = 64'h1000;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h1000, a);
                push_wr(12'h342, 64'hB, a + 4);
                push_wr(12'h300, 64'h1882, a + 6);
                push_redir(64'hFFFF_FFFF_FFFF_FFFC, a + 8);
                wait_edge();
                ecall_i = 1'b0;
                wait_edge();
                stall_i = 1'b1;
                #1;
                chk("stall_forces_we_low", {63'd0, csr_we_o}, 64'd0);
                repeat (3) wait_edge();
                chk("busy_held_in_stall", {63'd0, busy_o}, 64'd1);
                stall_i = 1'b0;
                wait_idle("stall_done");

                // Asynchronous reset while in WR_MSTATUS.
                mstatus_m = 64'h8;
                mtvec_m   = 64'h8000_0103;
                ecall_i = 1'b1; pc_i = 64'h2222_0000;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h2222_0000, a);
                push_wr(12'h342, 64'hB, a + 1);
                wait_edge();
                ecall_i = 1'b0;
                repeat (3) wait_edge();
                chk("in_wr_mstatus_addr", {52'd0, csr_waddr_o}, 64'h300);
                #1 rst = 1'b1;
                #1;
                chk("midrst_busy", {63'd0, busy_o}, 64'd0);
                chk("midrst_strobes", {61'd0, csr_we_o, csr_re_o, redirect_o}, 64'd0);
                chk("midrst_wdata", csr_wdata_o, 64'd0);
                #1 rst = 1'b0;
                repeat (8) wait_edge();
                chk("after_midrst_idle", {63'd0, busy_o}, 64'd0);

                // Back-to-back ecalls with a single IDLE cycle between.
                mstatus_m = 64'h0;
                ecall_i = 1'b1; pc_i = 64'h100;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h100, a);
                push_wr(12'h342, 64'hB, a + 1);
                push_wr(12'h300, 64'h1800, a + 3);
                push_redir(64'h8000_0100, a + 5);
                wait_edge();
                ecall_i = 1'b0;
                repeat (6) wait_edge();
                chk("b2b_idle_gap", {63'd0, busy_o}, 64'd0);
                mstatus_m = 64'h88;
                ecall_i = 1'b1; pc_i = 64'h200;
                a = cyc_cnt + 1;
                push_wr(12'h341, 64'h200, a);
                push_wr(12'h342, 64'hB, a + 1);
                push_wr(12'h300, 64'h1880, a + 3);
                push_redir(64'h8000_0100, a + 5);
                wait_edge();
                ecall_i = 1'b0;
                wait_idle("b2b_done");

                repeat (2) wait_edge();
                chk("queue_drained", 64'(exp_q.size()), 64'd0);
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
